// File: rtl/mc_main_controller.sv
// Multi-cycle MIPS main control FSM: sequences one instruction at a time and
// decodes datapath selects, write enables and the 2-bit ALU-controller op.
module mc_main_controller #(
  parameter logic [5:0] ADDR_JR = 6'b001000,
  parameter int         STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_write_cond_n,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    S_IF       = STATE_W'(0),
    S_ID       = STATE_W'(1),
    S_MEM_ADDR = STATE_W'(2),
    S_MEM_RD   = STATE_W'(3),
    S_WB_LW    = STATE_W'(4),
    S_MEM_WR   = STATE_W'(5),
    S_EX_R     = STATE_W'(6),
    S_WB_R     = STATE_W'(7),
    S_BRANCH   = STATE_W'(8),
    S_JUMP     = STATE_W'(9),
    S_JAL      = STATE_W'(10),
    S_JR       = STATE_W'(11),
    S_ADDI_EX  = STATE_W'(12),
    S_ADDI_WB  = STATE_W'(13),
    S_ILLEGAL  = STATE_W'(14)
  } state_t;

  state_t r_state;
  state_t w_next_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: only ID and MEM_ADDR look at the instruction fields.
  always_comb begin
    w_next_state = S_IF;
    case (r_state)
      S_IF: w_next_state = S_ID;
      S_ID: begin
        case (opcode)
          OP_RTYPE:      w_next_state = (func == ADDR_JR) ? S_JR : S_EX_R;
          OP_LW, OP_SW:  w_next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
          OP_J:          w_next_state = S_JUMP;
          OP_JAL:        w_next_state = S_JAL;
          OP_ADDI:       w_next_state = S_ADDI_EX;
          default:       w_next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: w_next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next_state = S_WB_LW;
      S_EX_R:     w_next_state = S_WB_R;
      S_ADDI_EX:  w_next_state = S_ADDI_WB;
      default:    w_next_state = S_IF;
    endcase
  end

  // Moore output decode; reset masks everything so no write leaks during it.
  always_comb begin
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    pc_write_cond_n = 1'b0;
    i_or_d          = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    reg_dst         = 2'b00;
    mem_to_reg      = 2'b00;
    reg_write       = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    pc_src          = 2'b00;
    instr_done      = 1'b0;
    illegal         = 1'b0;
    state           = r_state;

    case (r_state)
      S_IF: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_ID: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = 1'b1;
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        pc_src          = 2'b01;
        instr_done      = 1'b1;
        pc_write_cond   = (opcode == OP_BEQ);
        pc_write_cond_n = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        alu_op     = 2'b11;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        alu_op     = 2'b11;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_src     = 2'b11;
        alu_op     = 2'b11;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    if (rst) begin
      pc_write        = 1'b0;
      pc_write_cond   = 1'b0;
      pc_write_cond_n = 1'b0;
      i_or_d          = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      ir_write        = 1'b0;
      reg_dst         = 2'b00;
      mem_to_reg      = 2'b00;
      reg_write       = 1'b0;
      alu_src_a       = 1'b0;
      alu_src_b       = 2'b00;
      alu_op          = 2'b00;
      pc_src          = 2'b00;
      instr_done      = 1'b0;
      illegal         = 1'b0;
      state           = '0;
    end
  end

endmodule

// File: tb/tb_mc_main_controller.sv
// Bench for mc_main_controller: directed and random instruction streams
// checked cycle by cycle against a per-instruction-class behavioural model.
module tb_mc_main_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       pc_write, pc_write_cond, pc_write_cond_n, i_or_d;
  logic       mem_read, mem_write, ir_write, reg_write, alu_src_a;
  logic       instr_done, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_main_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_write_cond_n(pc_write_cond_n), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal),
    .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcc, pcn, iord, mr, mw, irw;
    logic [1:0] rd, m2r;
    logic       rw, asa;
    logic [1:0] asb, aop, psrc;
    logic       done, ill;
  } exp_t;

  function automatic exp_t observed();
    exp_t o;
    o = {state, pc_write, pc_write_cond, pc_write_cond_n, i_or_d, mem_read,
         mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
         alu_src_b, alu_op, pc_src, instr_done, illegal};
    return o;
  endfunction

  function automatic string classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? "jr" : "r";
      6'b100011: return "lw";
      6'b101011: return "sw";
      6'b000100: return "beq";
      6'b000101: return "bne";
      6'b000010: return "j";
      6'b000011: return "jal";
      6'b001000: return "addi";
      default:   return "ill";
    endcase
  endfunction

  function automatic int latency(string c);
    if (c == "lw") return 5;
    if (c == "sw" || c == "r" || c == "addi") return 4;
    return 3;
  endfunction

  // Expected control word for cycle k (0 = IF) of an instruction.
  function automatic exp_t model(logic [5:0] op, logic [5:0] fn, int k);
    exp_t  e;
    string c;
    e = '0;
    c = classify(op, fn);
    if (k == 0) begin
      e.st = 4'd0; e.mr = 1; e.irw = 1; e.pcw = 1; e.asb = 2'b01;
    end else if (k == 1) begin
      e.st = 4'd1; e.asb = 2'b11;
    end else if (c == "lw" || c == "sw") begin
      if (k == 2) begin
        e.st = 4'd2; e.asa = 1; e.asb = 2'b10;
      end else if (c == "sw") begin
        e.st = 4'd5; e.mw = 1; e.iord = 1; e.done = 1;
      end else if (k == 3) begin
        e.st = 4'd3; e.mr = 1; e.iord = 1;
      end else begin
        e.st = 4'd4; e.rw = 1; e.m2r = 2'b01; e.done = 1;
      end
    end else if (c == "r") begin
      if (k == 2) begin e.st = 4'd6; e.asa = 1; e.aop = 2'b10; end
      else begin e.st = 4'd7; e.rw = 1; e.rd = 2'b01; e.done = 1; end
    end else if (c == "addi") begin
      if (k == 2) begin e.st = 4'd12; e.asa = 1; e.asb = 2'b10; end
      else begin e.st = 4'd13; e.rw = 1; e.done = 1; end
    end else if (c == "beq" || c == "bne") begin
      e.st = 4'd8; e.asa = 1; e.aop = 2'b01; e.psrc = 2'b01; e.done = 1;
      e.pcc = (c == "beq"); e.pcn = (c == "bne");
    end else if (c == "j") begin
      e.st = 4'd9; e.pcw = 1; e.psrc = 2'b10; e.aop = 2'b11; e.done = 1;
    end else if (c == "jal") begin
      e.st = 4'd10; e.pcw = 1; e.psrc = 2'b10; e.rw = 1; e.rd = 2'b10;
      e.m2r = 2'b10; e.aop = 2'b11; e.done = 1;
    end else if (c == "jr") begin
      e.st = 4'd11; e.pcw = 1; e.psrc = 2'b11; e.aop = 2'b11; e.done = 1;
    end else begin
      e.st = 4'd14; e.ill = 1;
    end
    return e;
  endfunction

  task automatic check(string tag, exp_t exp);
    exp_t obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    total++;
    assert (((reg_write & mem_write) | (pc_write_cond & pc_write_cond_n) |
             (instr_done & illegal)) === 1'b0) else begin
      bad++;
      $error("FAIL %s_exclusive observed=1 expected=0", tag);
    end
  endtask

  // Entered and left at a negedge with the DUT in IF.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn);
    string c;
    c = classify(op, fn);
    opcode = op;
    func   = fn;
    #1;
    for (int k = 0; k < latency(c); k++) begin
      check($sformatf("%s_c%0d", c, k), model(op, fn, k));
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    $display("instr %-4s op=%b fn=%b cycles=%0d", c, op, fn, latency(c));
  endtask

  task automatic check_reset(string tag);
    exp_t zero;
    zero = '0;
    check(tag, zero);
  endtask

  logic [5:0] pool [8];
  logic [5:0] rop, rfn;

  initial begin
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
             6'b000101, 6'b000010, 6'b000011, 6'b001000};
    rst = 1'b1; opcode = 6'd0; func = 6'd0;
    @(negedge clk); #1;
    check_reset("reset_hold0");
    @(posedge clk); @(negedge clk); #1;
    check_reset("reset_hold1");
    rst = 1'b0;

    // Reset for two edges while in EX_R of an R-type add.
    opcode = 6'b000000; func = 6'b100000; #1;
    check("abort_if", model(opcode, func, 0));
    @(posedge clk); @(negedge clk); #1;
    check("abort_id", model(opcode, func, 1));
    @(posedge clk); @(negedge clk); #1;
    check("abort_exr", model(opcode, func, 2));
    rst = 1'b1; #1;
    check_reset("reset_in_exr");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk); #1;
      check_reset($sformatf("reset_edge%0d", i));
    end
    rst = 1'b0;

    run_instr(6'b000000, 6'b100000);   // add
    run_instr(6'b100011, 6'b000000);   // lw
    run_instr(6'b101011, 6'b000000);   // sw
    run_instr(6'b000100, 6'b000000);   // beq
    run_instr(6'b000101, 6'b000000);   // bne
    run_instr(6'b000011, 6'b000000);   // jal
    run_instr(6'b000000, 6'b001000);   // jr
    run_instr(6'b000010, 6'b000000);   // j
    run_instr(6'b111111, 6'b000000);   // illegal
    run_instr(6'b001000, 6'b000000);   // addi after illegal

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) rop = 6'($urandom_range(0, 63));
      else rop = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 2) == 0) rfn = 6'b001000;
      else rfn = 6'($urandom_range(0, 63));
      run_instr(rop, rfn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
